// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and a
// constant-evaluable ceiling-log2 helper used to size pointers and counters.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
// The request vector is doubled so the wrapped search becomes one priority scan.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;

    assign dbl = {req, req};

    // Bits of the lower copy below ptr are masked off; the upper copy supplies the wrap.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (!found && dbl[k] && (k >= int'(ptr))) begin
                found = 1'b1;
                idx   = PTR_W'(k % NUM_REQ);
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
        any = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-producer accepted-word counters (word_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DIN_WIDTH = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_din,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DIN_WIDTH-1:0]           fifo_din,
    output logic                           fifo_wr_en,
    input  logic                           fifo_full,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]          word_cnt
`endif
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BURST_LEN + 1);

    arb_state_e                          state_q, state_d;
    logic [NUM_REQ-1:0]                  grant_q, grant_d;
    logic [PTR_W-1:0]                    gidx_q, gidx_d;
    logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                    beat_q, beat_d;

    logic [NUM_REQ-1:0][DIN_WIDTH-1:0]   din_arr;
    logic [NUM_REQ-1:0]                  pick_onehot;
    logic [PTR_W-1:0]                    pick_idx;
    logic                                pick_any;
    logic                                owner_valid;
    logic                                last_beat;

    assign din_arr     = req_din;
    assign owner_valid = req_valid[gidx_q];
    assign last_beat   = (beat_q == CNT_W'(BURST_LEN - 1));
    assign busy        = (state_q == ST_BURST);
    assign grant       = grant_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Outputs are forced quiet while rst is high so a mid-burst reset never writes.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (busy) begin
            fifo_din = din_arr[gidx_q];
            if (!fifo_full && !rst) begin
                req_ready  = grant_q;
                fifo_wr_en = owner_valid;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !fifo_full) begin
                    state_d = ST_BURST;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                if (!owner_valid || (fifo_wr_en && last_beat)) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end else if (fifo_wr_en) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (fifo_wr_en) begin
            word_cnt_q[gidx_q] <= word_cnt_q[gidx_q] + 32'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DIN_WIDTH=8, BURST_LEN=4).
// Producer i offers words i*16+n; every FIFO write is logged and checked at the end.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_din;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic [3:0]  grant;
    logic        busy;
`ifdef FIFO_ARB_STATS_EN
    logic [127:0] word_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int n[4]     = '{0, 0, 0, 0};
    logic [7:0] wlog[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DIN_WIDTH (8),
        .BURST_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_din    (req_din),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant      (grant),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive producer data, let combinational outputs settle, record any write/handshake.
    task automatic settle();
        for (int i = 0; i < 4; i++) req_din[i*8 +: 8] = 8'(i * 16 + n[i]);
        #1;
        if (fifo_wr_en) wlog.push_back(fifo_din);
        for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) n[i]++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int         ord[5];
        int         wr_cnt;
        logic [3:0] g1;
        logic [7:0] exp_log[30];

        ord = '{0, 1, 2, 3, 0};
        exp_log = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                    8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
                    8'h04, 8'h05, 8'h06, 8'h07, 8'h20, 8'h21, 8'h22, 8'h23,
                    8'h24, 8'h25, 8'h14, 8'h15, 8'h08, 8'h09};
        rst       = 1'b1;
        req_valid = 4'hF;
        fifo_full = 1'b0;
        req_din   = '0;
        @(negedge clk);

        // Reset held with every producer valid
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            tick();
        end
        rst = 1'b0;
        settle();
        chk("rel_idle_grant", 32'(grant), 32'h0);
        chk("rel_idle_wr", 32'(fifo_wr_en), 32'h0);
        tick();

        // All producers valid: grants 0,1,2,3,0 with a bubble between bursts
        wr_cnt = 0;
        for (int r = 0; r < 5; r++) begin
            g1 = 4'b0001 << ord[r];
            for (int b = 0; b < 4; b++) begin
                settle();
                chk("s2_grant", 32'(grant), 32'(g1));
                chk("s2_wr_en", 32'(fifo_wr_en), 32'h1);
                chk("s2_din", 32'(fifo_din), 32'(ord[r] * 16 + ((r == 4) ? 4 : 0) + b));
                if (r < 4 && fifo_wr_en) wr_cnt++;
                tick();
            end
            if (r == 4) begin
                req_valid = 4'b0100;
                n[2]      = 0;
            end
            settle();
            chk("s2_bubble_grant", 32'(grant), 32'h0);
            chk("s2_bubble_wr", 32'(fifo_wr_en), 32'h0);
            tick();
            if (r == 3) chk("s2_16_in_20", 32'(wr_cnt), 32'd16);
        end

        // Only producer 2: two words then valid drops
        settle();
        chk("s3_grant", 32'(grant), 32'h4);
        chk("s3_din0", 32'(fifo_din), 32'h20);
        tick();
        settle();
        chk("s3_din1", 32'(fifo_din), 32'h21);
        chk("s3_wr1", 32'(fifo_wr_en), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        chk("s3_drop_wr", 32'(fifo_wr_en), 32'h0);
        chk("s3_drop_busy", 32'(busy), 32'h1);
        tick();
        settle();
        chk("s3_idle_grant", 32'(grant), 32'h0);
        chk("s3_idle_busy", 32'(busy), 32'h0);
        tick();
        req_valid = 4'b0100;
        settle();
        chk("s3_rearb_grant", 32'(grant), 32'h0);
        tick();

        // Producer 2 re-granted; FIFO full for 5 cycles after two words
        settle();
        chk("s4_grant", 32'(grant), 32'h4);
        chk("s4_din0", 32'(fifo_din), 32'h22);
        tick();
        settle();
        chk("s4_din1", 32'(fifo_din), 32'h23);
        tick();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("s4_full_wr", 32'(fifo_wr_en), 32'h0);
            chk("s4_full_ready", 32'(req_ready), 32'h0);
            chk("s4_full_grant", 32'(grant), 32'h4);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        chk("s4_din2", 32'(fifo_din), 32'h24);
        chk("s4_wr2", 32'(fifo_wr_en), 32'h1);
        tick();
        settle();
        chk("s4_din3", 32'(fifo_din), 32'h25);
        chk("s4_wr3", 32'(fifo_wr_en), 32'h1);
        tick();
        // Pointer now sits at 3, so producer 1 beats producer 2
        req_valid = 4'b0110;
        settle();
        chk("s4_exit_grant", 32'(grant), 32'h0);
        chk("s4_exit_wr", 32'(fifo_wr_en), 32'h0);
        tick();

        // Reset in the middle of a producer-1 burst
        settle();
        chk("s5_grant", 32'(grant), 32'h2);
        chk("s5_din0", 32'(fifo_din), 32'h14);
        tick();
        settle();
        chk("s5_din1", 32'(fifo_din), 32'h15);
        tick();
        rst = 1'b1;
        settle();
        chk("s5_rst_wr", 32'(fifo_wr_en), 32'h0);
        chk("s5_rst_ready", 32'(req_ready), 32'h0);
`ifdef FIFO_ARB_STATS_EN
        chk("s5_cnt0", word_cnt[31:0], 32'd8);
        chk("s5_cnt1", word_cnt[63:32], 32'd6);
        chk("s5_cnt2", word_cnt[95:64], 32'd10);
        chk("s5_cnt3", word_cnt[127:96], 32'd4);
`endif
        tick();
        rst       = 1'b0;
        req_valid = 4'hF;
        settle();
        chk("s5_post_grant", 32'(grant), 32'h0);
        chk("s5_post_busy", 32'(busy), 32'h0);
        tick();
        for (int b = 0; b < 4; b++) begin
            settle();
            chk("s5_restart_grant", 32'(grant), 32'h1);
            chk("s5_restart_din", 32'(fifo_din), 32'(8 + b));
            chk("s5_restart_wr", 32'(fifo_wr_en), 32'h1);
            tick();
        end
        req_valid = 4'b0000;
        settle();
        chk("end_grant", 32'(grant), 32'h0);
        chk("end_wr", 32'(fifo_wr_en), 32'h0);
        tick();
`ifdef FIFO_ARB_STATS_EN
        chk("end_cnt0", word_cnt[31:0], 32'd4);
        chk("end_cnt1", word_cnt[63:32], 32'd0);
        chk("end_cnt2", word_cnt[95:64], 32'd0);
        chk("end_cnt3", word_cnt[127:96], 32'd0);
`endif

        // Whole write stream in order (last two words 0x0A, 0x0B appended below)
        chk("log_len", 32'(wlog.size()), 32'd32);
        for (int i = 0; i < 30; i++) begin
            chk("log_word", (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(exp_log[i]));
        end
        chk("log_word30", (wlog.size() > 30) ? 32'(wlog[30]) : 32'hFFFF_FFFF, 32'h0A);
        chk("log_word31", (wlog.size() > 31) ? 32'(wlog[31]) : 32'hFFFF_FFFF, 32'h0B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
